// File: rtl/dsp_result_collector_if.sv
// Bundles the DSP result stream and the consumer handshake of dsp_result_collector.
// A beat moves on a rising clk edge where the sender holds valid high and the receiver holds ready high.
// A sender must not drop valid or change its payload until that beat has moved.
interface dsp_result_collector_if #(
  parameter int WIDTH = 16
);
  logic                 res_valid;
  logic                 res_last;
  logic [2*WIDTH-1:0]   res_data;
  logic                 m_valid;
  logic                 m_ready;
  logic [2*WIDTH-1:0]   m_data;
  logic                 m_sat;

  modport master (
    output res_valid, res_last, res_data, m_ready,
    input  m_valid, m_data, m_sat
  );

  modport slave (
    input  res_valid, res_last, res_data, m_ready,
    output m_valid, m_data, m_sat
  );
endinterface

// File: rtl/dsp_result_collector.sv
// Aligns the DSP compare_res strobe with its delayed result bus and queues accepted results in a FIFO.
// Optional feature macro COLLECT_SAT_EN: clamp stored results to a signed OUT_WIDTH range and flag clamping.
module dsp_result_collector #(
  parameter int WIDTH         = 16,
  parameter int PIPELINE_BITS = 3,
  parameter int DEPTH         = 4,
  parameter int OUT_WIDTH     = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  dsp_result_collector_if.slave     bus,
  input  logic [PIPELINE_BITS-1:0]  pipe_stages,
  input  logic                      last_only,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow,
  input  logic                      clr_ovf
);
  localparam int RW = 2 * WIDTH;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if (OUT_WIDTH < 2 || OUT_WIDTH >= RW || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("dsp_result_collector: unsupported OUT_WIDTH or DEPTH");
  end

  logic [PIPELINE_BITS-1:0] ps_q, ps_d;
  logic [PIPELINE_BITS-1:0] vtag_q, vtag_d, ltag_q, ltag_d;
  logic [AW-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]            count_q, count_d;
  logic                     ovf_q, ovf_d;
  logic [RW-1:0]            mem_q [DEPTH];
  logic [RW-1:0]            mem_d [DEPTH];

  logic                     ps_changed, aligned_valid, aligned_last;
  logic                     push, pop, full, wr_en, drop;
  logic [RW-1:0]            store_data;
  logic                     store_sat;
  int unsigned              d_eff;

  // Tag delay line; any change of pipe_stages flushes every in-flight tag.
  always_comb begin
    ps_d       = pipe_stages;
    ps_changed = (pipe_stages != ps_q);
    vtag_d     = '0;
    ltag_d     = '0;
    if (!ps_changed) begin
      vtag_d[0] = bus.res_valid;
      ltag_d[0] = bus.res_last;
      for (int i = 1; i < PIPELINE_BITS; i++) begin
        vtag_d[i] = vtag_q[i-1];
        ltag_d[i] = ltag_q[i-1];
      end
    end
    d_eff = (32'(ps_q) > PIPELINE_BITS) ? PIPELINE_BITS : 32'(ps_q);
    aligned_valid = bus.res_valid;
    aligned_last  = bus.res_last;
    for (int i = 1; i <= PIPELINE_BITS; i++) begin
      if (d_eff == i) begin
        aligned_valid = vtag_q[i-1];
        aligned_last  = ltag_q[i-1];
      end
    end
    if (ps_changed) aligned_valid = 1'b0;
  end

`ifdef COLLECT_SAT_EN
  localparam logic signed [RW-1:0] SAT_MAX = {{(RW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [RW-1:0] SAT_MIN = {{(RW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
  logic [DEPTH-1:0] sat_q, sat_d;

  always_comb begin
    store_data = bus.res_data;
    store_sat  = 1'b0;
    if ($signed(bus.res_data) > SAT_MAX) begin
      store_data = SAT_MAX;
      store_sat  = 1'b1;
    end else if ($signed(bus.res_data) < SAT_MIN) begin
      store_data = SAT_MIN;
      store_sat  = 1'b1;
    end
    sat_d = sat_q;
    if (wr_en) sat_d[wr_ptr_q] = store_sat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sat_q <= '0;
    else        sat_q <= sat_d;
  end

  assign bus.m_sat = sat_q[rd_ptr_q];
`else
  always_comb begin
    store_data = bus.res_data;
    store_sat  = 1'b0;
  end

  assign bus.m_sat = store_sat;
`endif

  always_comb begin
    push  = aligned_valid & (~last_only | aligned_last);
    pop   = bus.m_valid & bus.m_ready;
    full  = (count_q == CW'(DEPTH));
    wr_en = push & (~full | pop);
    drop  = push & full & ~pop;

    mem_d = mem_q;
    if (wr_en) mem_d[wr_ptr_q] = store_data;
    wr_ptr_d = wr_ptr_q + (wr_en ? AW'(1) : AW'(0));
    rd_ptr_d = rd_ptr_q + (pop ? AW'(1) : AW'(0));

    count_d = count_q;
    if (wr_en && !pop)      count_d = count_q + CW'(1);
    else if (!wr_en && pop) count_d = count_q - CW'(1);

    // A drop in the same cycle as a clear wins, so no overflow is lost.
    ovf_d = ovf_q;
    if (drop)         ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps_q     <= '0;
      vtag_q   <= '0;
      ltag_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      ps_q     <= ps_d;
      vtag_q   <= vtag_d;
      ltag_q   <= ltag_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      mem_q    <= mem_d;
    end
  end

  assign bus.m_valid = (count_q != '0);
  assign bus.m_data  = mem_q[rd_ptr_q];
  assign count       = count_q;
  assign overflow    = ovf_q;
endmodule

// File: doc/dsp_result_collector.md
# dsp_result_collector

Downstream capture stage for the DSP MAC slice. It takes the slice's `compare_res` valid strobe and its `out` result bus, delays the strobe by the configured pipe-stage count so it lines up with the data, and optionally keeps only the final beat of each MAC chain. Accepted results go into a small FIFO, which a consumer drains through a valid/ready handshake.

## Interface
- `WIDTH`, 16: DSP operand width; result width is 2*WIDTH.
- `PIPELINE_BITS`, 3: must match the DSP instance; maximum alignment delay is PIPELINE_BITS cycles.
- `DEPTH`, 4: FIFO entries; power of two, at least 2.
- `OUT_WIDTH`, 16: saturation width; used only with COLLECT_SAT_EN.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `res_valid`  in  1  DSP `compare_res`, undelayed.
- `res_last`  in  1  chain-end marker, same cycle as `res_valid`; high on the final MAC beat.
- `res_data`  in  2*WIDTH  DSP `out`, already delayed by the DSP's pipe stages.
- `pipe_stages`  in  PIPELINE_BITS  same value driven to the DSP.
- `last_only`  in  1  1 = capture only beats with `res_last`=1.
- `m_valid`  out  1  FIFO head valid.
- `m_ready`  in  1  consumer accepts the head.
- `m_data`  out  2*WIDTH  FIFO head result.
- `m_sat`  out  1  head entry was saturated.
- `count`  out  $clog2(DEPTH)+1  current occupancy.
- `overflow`  out  1  sticky; set when a push is dropped.
- `clr_ovf`  in  1  synchronous clear of `overflow`.

## Operation
- **Alignment.**
  - `valid` and `last` pass through a tag delay line of PIPELINE_BITS registers.
  - Effective delay d = min(`pipe_stages`, PIPELINE_BITS).
  - d = 0 uses the inputs directly.
  - The aligned tag is sampled together with `res_data` in the same cycle.
- **pipe_stages change.** `pipe_stages` is registered. A change between consecutive cycles clears every tag in the delay line, so in-flight results are discarded and not captured.
- **Push condition.** push = aligned_valid & (~`last_only` | aligned_last).
- **Pop condition.** pop = `m_valid` & `m_ready`.
- **FIFO structure.** Circular buffer with read and write pointers that wrap modulo DEPTH. `count` is tracked explicitly.
- **Boundary cases.**
  - Full, push, no pop: the push is dropped, `overflow` is set, and contents are unchanged.
  - Full, push and pop in the same cycle: both happen and `count` stays at DEPTH.
  - Empty, push and `m_ready`=1: the entry is written. `m_valid` rises the next cycle; there is no fall-through.
  - Pop while empty cannot occur, because pop requires `m_valid`.
- **Handshake.** `m_data` and `m_sat` stay stable while `m_valid`=1 and `m_ready`=0.
- **overflow.** Sticky until `clr_ovf`. If `clr_ovf` and a new drop occur in the same cycle, `overflow` stays 1.
- **Reset.**
  - On `rst_n` low: pointers, `count`, tag delay line, registered `pipe_stages` and `overflow` go to 0.
  - Outputs during reset: `m_valid`=0, `m_data`=0, `m_sat`=0, `count`=0.
  - Reset mid-operation discards all queued and in-flight results.

## Timing
- Let `res_valid`=1 at cycle t. `res_data` is captured at t+d and `m_valid` goes high at t+d+1.
- Sustained throughput is one push and one pop per cycle.
- `count` updates the cycle after the push or pop.
- `overflow` sets the cycle after the dropped push.
- All outputs come straight from registers or FIFO storage, with no combinational path from inputs.
- Exception: `m_data` and `m_sat` are a read-pointer mux of storage; `m_ready` does not feed them combinationally.

## Configuration
- Macro: `COLLECT_SAT_EN`.
- **Defined.**
  - At push, `res_data` is clamped to the signed OUT_WIDTH range [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - The clamped value is stored sign-extended to 2*WIDTH.
  - A 1-bit per-entry flag records whether clamping happened; `m_sat` presents that flag for the head entry.
- **Undefined.**
  - `res_data` is stored unmodified.
  - There is no per-entry flag storage, and `m_sat` is tied to 0.

## Test plan
- Reset: WIDTH=16, `pipe_stages`=2; pulse `res_valid` at cycle 10 with `res_data`=0x0000_1234 at cycle 12 → `m_valid`=1 at cycle 13 with `m_data`=0x0000_1234, `count`=1.
- `last_only`=1: four beats with `res_last`=0,0,0,1 and data 1,2,3,10 → only 10 is queued; `count`=1.
- Fill past full: DEPTH=4, `m_ready`=0, push values 1..5 → `count`=4, `overflow`=1. Drain returns 1,2,3,4. `clr_ovf` → `overflow`=0.
- Simultaneous push and pop at full: `count` stays 4 and order is preserved. `m_ready` toggled randomly over 100 pushes → output sequence equals input sequence.
- `pipe_stages` changed from 3 to 1 with 2 results in flight → neither is captured; the next result appears d=1 later.
- COLLECT_SAT_EN defined, OUT_WIDTH=16:
  - push 0x0001_0000 → `m_data`=0x0000_7FFF, `m_sat`=1.
  - push 0xFFFF_8000 → `m_data`=0xFFFF_8000, `m_sat`=0.
- Reset asserted with 3 entries queued → `m_valid`=0 and `count`=0 immediately.
